// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// a one-hot to binary index helper used to turn a grant vector into an index.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LAUNCH    = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } arb_state_t;

   // Largest supported requester count; the index helper is sized for it.
   localparam int MAX_REQ = 8;

   // Binary index of a one-hot vector (up to MAX_REQ bits); zero if empty.
   function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < MAX_REQ; i++) begin
         idx = idx | (oh[i] ? 3'(i) : 3'd0);
      end
      return idx;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: returns a one-hot winner among the set request bits,
// searching upward from pointer+1 (wrapping) so the last winner has lowest
// priority. Purely combinational.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] pointer,
   output logic [N_REQ-1:0] grant,
   output logic             valid
);

   // First set request at distance 1..N_REQ from the pointer wins.
   always_comb begin
      grant = {N_REQ{1'b0}};
      valid = 1'b0;
      for (int off = 1; off <= N_REQ; off++) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (!valid && req[k] && (((int'(pointer) + off) % N_REQ) == k)) begin
               grant[k] = 1'b1;
               valid    = 1'b1;
            end else begin
               grant[k] = grant[k];
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart_tx serializer between
// N_REQ byte producers. Launches one byte at a time, pulses start and a
// one-hot ack, then waits for the serializer to go busy and return to done.
// Optional feature macro: UART_ARB_LOCK_EN (previous winner holding i_lock
// keeps the grant so multi-byte packets stay contiguous).
module uart_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [N_REQ*8-1:0] i_data,
   input  logic [N_REQ-1:0]   i_lock,
   output logic [N_REQ-1:0]   o_ack,
   output logic [IDX_W-1:0]   o_grant_id,
   output logic               o_active,
   output logic               o_start_tx,
   output logic [7:0]         o_tx_data,
   input  logic               i_tx_busy,
   input  logic               i_tx_done
);

   import uart_pkg::*;

   localparam logic [N_REQ-1:0] ONE_C = {{(N_REQ-1){1'b0}}, 1'b1};

   arb_state_t       state_r;
   logic [IDX_W-1:0] ptr_r;
   logic [N_REQ-1:0] pick_grant_s;
   logic             pick_valid_s;
   logic [IDX_W-1:0] pick_idx_s;
   logic [IDX_W-1:0] win_idx_s;
   logic             win_ok_s;
   logic             launch_ok_s;
   logic [7:0]       data_sel_s;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req     (i_req),
      .pointer (ptr_r),
      .grant   (pick_grant_s),
      .valid   (pick_valid_s)
   );

   // Binary index of the round-robin winner.
   always_comb begin
      pick_idx_s = IDX_W'(onehot_to_idx(MAX_REQ'(pick_grant_s)));
   end

`ifdef UART_ARB_LOCK_EN
   logic had_win_r;

   // Remember that o_grant_id names a real previous winner (not reset value).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         had_win_r <= 1'b0;
      end else if (state_r == S_IDLE && launch_ok_s) begin
         had_win_r <= 1'b1;
      end else begin
         had_win_r <= had_win_r;
      end
   end

   // Locked previous winner overrides the round-robin choice.
   always_comb begin
      win_idx_s = pick_idx_s;
      win_ok_s  = pick_valid_s;
      if (had_win_r && i_lock[o_grant_id] && i_req[o_grant_id]) begin
         win_idx_s = o_grant_id;
         win_ok_s  = 1'b1;
      end else begin
         win_idx_s = pick_idx_s;
      end
   end
`else
   logic lock_unused_s;

   // Lock inputs are ignored in the pure round-robin build.
   always_comb begin
      lock_unused_s = ^i_lock;
      win_idx_s     = pick_idx_s;
      win_ok_s      = pick_valid_s;
   end
`endif

   // Launch only when a winner exists and the serializer is idle and done.
   always_comb begin
      launch_ok_s = win_ok_s && !i_tx_busy && i_tx_done;
   end

   // Byte of the selected winner.
   always_comb begin
      data_sel_s = 8'h00;
      for (int k = 0; k < N_REQ; k++) begin
         if (win_idx_s == IDX_W'(k)) begin
            data_sel_s = i_data[k*8 +: 8];
         end else begin
            data_sel_s = data_sel_s;
         end
      end
   end

   // Sequencer FSM with registered start/ack/active, data and grant index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         ptr_r      <= IDX_W'(N_REQ-1);
         o_ack      <= {N_REQ{1'b0}};
         o_start_tx <= 1'b0;
         o_active   <= 1'b0;
         o_tx_data  <= 8'h00;
         o_grant_id <= {IDX_W{1'b0}};
      end else begin
         o_start_tx <= 1'b0;
         o_ack      <= {N_REQ{1'b0}};
         case (state_r)
            S_IDLE: begin
               if (launch_ok_s) begin
                  o_tx_data  <= data_sel_s;
                  o_grant_id <= win_idx_s;
                  ptr_r      <= win_idx_s;
                  o_active   <= 1'b1;
                  state_r    <= S_LAUNCH;
               end else begin
                  state_r    <= S_IDLE;
               end
            end
            S_LAUNCH: begin
               o_start_tx <= 1'b1;
               o_ack      <= ONE_C << o_grant_id;
               state_r    <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (i_tx_busy) begin
                  state_r <= S_WAIT_DONE;
               end else begin
                  state_r <= S_WAIT_BUSY;
               end
            end
            S_WAIT_DONE: begin
               if (!i_tx_busy && i_tx_done) begin
                  o_active <= 1'b0;
                  state_r  <= S_IDLE;
               end else begin
                  state_r  <= S_WAIT_DONE;
               end
            end
            default: begin
               o_active <= 1'b0;
               state_r  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx
// (CLK_PER_BIT = 4). Stimulus pushes expected launches; a negedge monitor
// checks every launch and decodes every serial frame.
module tb_uart_tx_arbiter;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;
   localparam int CPB   = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N_REQ-1:0]   i_req;
   logic [N_REQ*8-1:0] i_data;
   logic [N_REQ-1:0]   i_lock;
   logic [N_REQ-1:0]   o_ack;
   logic [IDX_W-1:0]   o_grant_id;
   logic               o_active;
   logic               o_start_tx;
   logic [7:0]         o_tx_data;
   logic               tx_busy = 1'b0;
   logic               tx_done = 1'b1;
   logic               tx_line = 1'b1;
   logic [9:0]         tx_frame = 10'h3FF;
   int                 tx_cnt = 0;
   int                 tx_bit = 0;

   uart_tx_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (i_req),
      .i_data     (i_data),
      .i_lock     (i_lock),
      .o_ack      (o_ack),
      .o_grant_id (o_grant_id),
      .o_active   (o_active),
      .o_start_tx (o_start_tx),
      .o_tx_data  (o_tx_data),
      .i_tx_busy  (tx_busy),
      .i_tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   // Behavioural uart_tx: start bit, 8 data bits LSB first, stop bit.
   always @(posedge clk) begin
      if (!tx_busy) begin
         if (o_start_tx) begin
            tx_busy  <= 1'b1;
            tx_done  <= 1'b0;
            tx_frame <= {1'b1, o_tx_data, 1'b0};
            tx_cnt   <= 0;
            tx_bit   <= 0;
            tx_line  <= 1'b0;
         end
      end else if (tx_cnt == CPB-1) begin
         tx_cnt <= 0;
         if (tx_bit == 9) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            tx_line <= 1'b1;
         end else begin
            tx_bit  <= tx_bit + 1;
            tx_line <= tx_frame[tx_bit+1];
         end
      end else begin
         tx_cnt <= tx_cnt + 1;
      end
   end

   typedef struct packed {
      logic [7:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   launch_at[$];
   int   checks   = 0;
   int   errors   = 0;
   int   negcount = 0;
   int   launches = 0;
   int   fall_neg = 0;
   logic prev_busy = 1'b0;
   logic rx_on = 1'b0;
   int   rx_ph = 0;
   logic [9:0] rx_bits = 10'h000;
   logic [7:0] rx_exp = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: checks each launch against the scoreboard and decodes frames.
   always @(negedge clk) begin
      exp_t e;
      int   j;
      negcount++;
      if (prev_busy && !tx_busy) fall_neg = negcount;
      prev_busy = tx_busy;
      if (o_start_tx || (o_ack != 4'b0000)) begin
         check("ack_with_start", {31'd0, (o_ack != 4'b0000)}, {31'd0, o_start_tx});
      end
      if (o_start_tx) begin
         launch_at.push_back(negcount);
         launches++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_launch actual_id=%0d required=none", o_grant_id);
         end else begin
            e = exp_q.pop_front();
            check("grant_id", 32'(o_grant_id), 32'(e.id));
            check("ack_onehot", 32'(o_ack), 32'(4'b0001 << e.id[1:0]));
            check("tx_data", 32'(o_tx_data), 32'(e.data));
            check("active_at_launch", 32'(o_active), 32'd1);
            rx_on  = 1'b1;
            rx_ph  = 0;
            rx_exp = e.data;
         end
      end else if (rx_on) begin
         rx_ph++;
         if (rx_ph >= 3 && ((rx_ph - 3) % CPB) == 0) begin
            j = (rx_ph - 3) / CPB;
            rx_bits[j] = tx_line;
            if (j == 9) begin
               check("serial_start_bit", 32'(rx_bits[0]), 32'd0);
               check("serial_byte", 32'(rx_bits[8:1]), 32'(rx_exp));
               check("serial_stop_bit", 32'(rx_bits[9]), 32'd1);
               rx_on = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic wait_launches(input int target, input int budget);
      for (int i = 0; i < budget && launches < target; i++) step();
      check("launch_within_budget", 32'(launches >= target), 32'd1);
   endtask

   task automatic settle();
      repeat (60) step();
      check("active_idle", 32'(o_active), 32'd0);
   endtask

   task automatic push_exp(input int id, input logic [7:0] data);
      exp_t e;
      e.id   = 8'(id);
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ack"}, 32'(o_ack), 32'd0);
      check({tag, "_start"}, 32'(o_start_tx), 32'd0);
      check({tag, "_active"}, 32'(o_active), 32'd0);
      check({tag, "_data"}, 32'(o_tx_data), 32'd0);
      check({tag, "_grant"}, 32'(o_grant_id), 32'd0);
   endtask

   initial begin
      int base;
      int n0;
      rst_n  = 1'b0;
      i_req  = 4'b0000;
      i_data = 32'h0000_0000;
      i_lock = 4'b0000;
      #1;
      check_outputs_zero("reset");
      do_reset();

      // Single request, 0xA5 from requester 0; start two negedges after drive.
      i_data[7:0] = 8'hA5;
      push_exp(0, 8'hA5);
      base = launches;
      n0 = negcount;
      i_req = 4'b0001;
      wait_launches(base + 1, 20);
      i_req = 4'b0000;
      if (launches > base) check("first_launch_latency", 32'(launch_at[base] - n0), 32'd2);
      settle();

      // Requesters 0 and 2 held: 0,2,0,2 at 44-cycle spacing.
      do_reset();
      i_data[7:0]   = 8'h3C;
      i_data[23:16] = 8'hC3;
      push_exp(0, 8'h3C); push_exp(2, 8'hC3); push_exp(0, 8'h3C); push_exp(2, 8'hC3);
      base = launches;
      i_req = 4'b0101;
      wait_launches(base + 4, 400);
      i_req = 4'b0000;
      if (launches >= base + 4) begin
         check("spacing_0_2", 32'(launch_at[base+1] - launch_at[base]), 32'd44);
         check("spacing_2_0", 32'(launch_at[base+2] - launch_at[base+1]), 32'd44);
      end
      settle();

      // All four from reset: 0,1,2,3, then requester 3 drops and 0 wins.
      do_reset();
      i_data = 32'h4433_2211;
      push_exp(0, 8'h11); push_exp(1, 8'h22); push_exp(2, 8'h33); push_exp(3, 8'h44);
      push_exp(0, 8'h11);
      base = launches;
      i_req = 4'b1111;
      wait_launches(base + 4, 400);
      i_req = 4'b0111;
      wait_launches(base + 5, 100);
      i_req = 4'b0000;
      settle();

      // Withdrawal: requester 1 raises and drops during requester 0's frame.
      i_data[7:0]  = 8'h5A;
      i_data[15:8] = 8'h77;
      push_exp(0, 8'h5A);
      base = launches;
      i_req = 4'b0001;
      wait_launches(base + 1, 20);
      i_req = 4'b0000;
      repeat (10) step();
      i_req = 4'b0010;
      repeat (20) step();
      i_req = 4'b0000;
      repeat (100) step();
      check("withdrawal_no_launch", 32'(launches), 32'(base + 1));
      check("active_after_withdrawal", 32'(o_active), 32'd0);

      // Reset mid-frame: outputs clear at once, pending request waits for done.
      i_data[7:0]  = 8'hC3;
      i_data[15:8] = 8'h96;
      push_exp(0, 8'hC3);
      base = launches;
      i_req = 4'b0001;
      wait_launches(base + 1, 20);
      i_req = 4'b0000;
      repeat (18) step();
      push_exp(1, 8'h96);
      i_req = 4'b0010;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midframe_reset");
      step();
      step();
      rst_n = 1'b1;
      wait_launches(base + 2, 200);
      i_req = 4'b0000;
      if (launches >= base + 2) check("launch_after_done", 32'(launch_at[base+1] - fall_neg), 32'd2);
      settle();

      // Lock on requester 2 with requests 1 and 2.
      do_reset();
      i_data[15:8]  = 8'h81;
      i_data[23:16] = 8'h42;
`ifdef UART_ARB_LOCK_EN
      push_exp(1, 8'h81); push_exp(2, 8'h42); push_exp(2, 8'h42); push_exp(2, 8'h42);
      push_exp(1, 8'h81);
`else
      push_exp(1, 8'h81); push_exp(2, 8'h42); push_exp(1, 8'h81); push_exp(2, 8'h42);
      push_exp(1, 8'h81);
`endif
      base = launches;
      i_req  = 4'b0110;
      i_lock = 4'b0100;
      wait_launches(base + 4, 400);
      i_lock = 4'b0000;
      wait_launches(base + 5, 100);
      i_req = 4'b0000;
      settle();

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
